tt_um_alu16_seq: RTL and testbench
==================================

# tt_um_alu16_seq

Host-facing sequencer that drives the team's 4-bit 74181-compatible slice (active-high data, active-low carry) to run 16-bit ALU operations nibble-serially. The host loads two 16-bit operands and a command byte over the 8-bit input bus. The block then runs four slice cycles, carrying between nibbles in a register, and returns the 16-bit result and flags over the output bus with a valid/ack handshake. It sits at the consuming end of the slice interface: it produces S, M, CNb and the A/B nibbles, and it consumes F, CN4b and A=B.

## Interface
- No parameters. Width is fixed at 16 bits, as 4 nibbles.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  unused
- ui_in  in  8  load byte: operand bytes, or the command byte {ignored[7:6], CNb[5], M[4], S[3:0]}
- uio_in  in  8  [0] in_valid, [1] out_ack, [7:2] ignored
- uo_out  out  8  result byte currently offered; 0 when out_valid=0
- uio_out  out  8  [2] in_ready, [3] out_valid, [4] cout, [5] aeb, [6] busy; [1:0], [7] = 0
- uio_oe  out  8  constant 8'b0111_1100

## Operation
- States: LOAD → EXEC → OUT0 → OUT1 → OUT2 → LOAD.
- **LOAD**
  - in_ready=1.
  - Each rising edge with in_valid=1 accepts ui_in into slot k, then k increments.
  - Slot order: A[7:0], A[15:8], B[7:0], B[15:8], CMD.
  - Acceptance of CMD (k=4) moves to EXEC and clears k.
- **EXEC**
  - busy=1, in_ready=0.
  - Four cycles, nibble index n=0..3.
  - Each cycle the slice evaluates A[4n+3:4n], B[4n+3:4n] with the latched S and M.
  - Slice carry input: the CMD CNb at n=0, otherwise the registered CN4b from nibble n-1.
  - F nibble n and the slice A=B bit are registered.
  - After n=3: move to OUT0.
- **Slice function.** The 74181 active-high truth table applies: M=1 selects logic, M=0 selects arithmetic. CNb=0 means carry-in. CN4b=0 means carry-out. Required codes:
  - M=0, S=1001: A plus B plus carry.
  - M=0, S=0110: A minus B minus 1 plus carry.
  - M=1, S=1011: A AND B.
  - M=1, S=1110: A OR B.
  - M=1, S=0110: A XOR B.
- **Flags**
  - cout = ~CN4b of nibble 3 (active-high), computed in both modes.
  - aeb = AND of the four nibble A=B bits, i.e. F==16'hFFFF.
  - Both hold from EXEC completion until the next CMD acceptance.
- **Output states.** out_valid=1 in each. Offered byte:
  - OUT0: F[7:0].
  - OUT1: F[15:8].
  - OUT2: {6'b0, aeb, cout}.
  - An edge with out_ack=1 advances to the next state. An ack in OUT2 returns to LOAD.
- **Ignored inputs**
  - in_valid outside LOAD.
  - out_ack outside OUT0–OUT2.
- Operand and CMD registers persist until overwritten by the next load.

## Timing
- **Reset (rst_n=0).** Takes effect immediately, independent of clk.
  - State=LOAD, k=0, registers cleared.
  - Outputs: uo_out=0, in_ready=1, out_valid=0, busy=0, cout=0, aeb=0.
- in_ready, out_valid, busy and uo_out are decoded from registered state only. There is no combinational path from uio_in.
- **Load rate.** One byte per cycle while in_valid stays high. Five valid cycles form a complete load, and in_valid high on consecutive edges loads consecutive slots.
- **Latency.**
  - CMD accepted at edge N.
  - EXEC runs during the cycles after edges N..N+3.
  - out_valid=1 after edge N+4, with byte 0 on uo_out.
- **Output rate.** out_ack held high drains one byte per edge: bytes 0, 1, 2, then LOAD with in_ready=1 on the following cycle.
- **Reset mid-load or mid-EXEC.** The partial load or computation is discarded. No output is produced, and the next complete 5-byte load behaves as after power-up.
- **Carry register.** Written only in EXEC. A stale carry never reaches nibble 0, which always uses the CMD CNb.

## Test plan
- **Add:** load A=0x1234, B=0x0FCD, CMD=0x29 (CNb=1, M=0, S=1001).
  - out_valid rises 4 cycles after CMD acceptance.
  - Bytes 0x01, 0x22, 0x00. cout=0, aeb=0.
- **Add wrap:** A=0xFFFF, B=0x0001, CMD=0x29.
  - Bytes 0x00, 0x00, 0x01. cout=1.
- **Subtract / compare:**
  - A=0x0005, B=0x0007, CMD=0x06 (CNb=0, M=0, S=0110): bytes 0xFE, 0xFF, 0x00.
  - A=B=0x5A5A, CMD=0x26: bytes 0xFF, 0xFF, 0x02 (aeb=1, cout=0).
- **Logic:** A=0xF0F0, B=0x3C3C.
  - CMD=0x3B (AND) → 0x3030.
  - CMD=0x3E (OR) → 0xFCFC.
  - CMD=0x36 (XOR) → 0xCCCC.
- **Handshake:**
  - in_valid pulses with gaps between bytes: only the valid-high edges load.
  - out_ack held low for 10 cycles: byte 0 is held stable.
  - in_valid asserted during EXEC/OUT: no effect.
- **Reset:**
  - rst_n dropped asynchronously mid-EXEC: all outputs return to reset values at once, and a following full add load returns the correct result.
  - rst_n dropped after 3 load bytes: k restarts at 0.

Source files
------------

// File: rtl/tt_um_alu16_seq.sv
// tt_um_alu16_seq: loads A, B and a command bytewise, runs a 74181-style slice nibble-serially, returns F and flags.
// Latency: out_valid rises 4 cycles after CMD acceptance; result bytes are held until out_ack, and in_valid is ignored while busy.
module tt_um_alu16_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [2:0] {ST_LOAD, ST_EXEC, ST_OUT0, ST_OUT1, ST_OUT2} state_t;

  state_t      r_state;
  logic [2:0]  r_k;
  logic [1:0]  r_n;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_f;
  logic [5:0]  r_cmd;
  logic [3:0]  r_eq;
  logic        r_cn4b;
  logic        r_cout;
  logic        r_aeb;
  logic        r_in_rdy;
  logic        r_out_vld;
  logic        r_busy;
  logic [7:0]  r_uo;

  logic       w_in_vld;
  logic       w_out_ack;
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_f;
  logic       w_carry;
  logic       w_cn4b;
  logic       w_unused;

  assign w_in_vld  = uio_in[0];
  assign w_out_ack = uio_in[1];
  assign w_unused  = &{1'b0, ena, ui_in[7:6], uio_in[7:2]};
  assign w_a       = r_a[{r_n, 2'b00} +: 4];
  assign w_b       = r_b[{r_n, 2'b00} +: 4];

  // Active-high 74181 slice: the carry chain runs in both modes, M only masks it out of F.
  always_comb begin
    w_carry = (r_n == 2'd0) ? ~r_cmd[5] : ~r_cn4b;
    w_g     = 4'b0;
    w_p     = 4'b0;
    w_f     = 4'b0;
    for (int i = 0; i < 4; i++) begin
      w_g[i]  = (w_a[i] & w_b[i] & r_cmd[3]) | (w_a[i] & ~w_b[i] & r_cmd[2]);
      w_p[i]  = w_a[i] | (w_b[i] & r_cmd[0]) | (~w_b[i] & r_cmd[1]);
      w_f[i]  = r_cmd[4] ? ~(w_p[i] ^ w_g[i]) : (w_p[i] ^ w_g[i] ^ w_carry);
      w_carry = w_g[i] | (w_p[i] & w_carry);
    end
    w_cn4b = ~w_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_LOAD;
      r_k       <= 3'd0;
      r_n       <= 2'd0;
      r_a       <= 16'h0;
      r_b       <= 16'h0;
      r_f       <= 16'h0;
      r_cmd     <= 6'h0;
      r_eq      <= 4'h0;
      r_cn4b    <= 1'b0;
      r_cout    <= 1'b0;
      r_aeb     <= 1'b0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_uo      <= 8'h0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_vld) begin
            case (r_k)
              3'd0:    r_a[7:0]  <= ui_in;
              3'd1:    r_a[15:8] <= ui_in;
              3'd2:    r_b[7:0]  <= ui_in;
              3'd3:    r_b[15:8] <= ui_in;
              default: r_cmd     <= ui_in[5:0];
            endcase
            if (r_k == 3'd4) begin
              r_k      <= 3'd0;
              r_n      <= 2'd0;
              r_state  <= ST_EXEC;
              r_in_rdy <= 1'b0;
              r_busy   <= 1'b1;
              r_cout   <= 1'b0;
              r_aeb    <= 1'b0;
            end else begin
              r_k <= r_k + 3'd1;
            end
          end
        end
        ST_EXEC: begin
          r_f[{r_n, 2'b00} +: 4] <= w_f;
          r_eq[r_n] <= &w_f;
          r_cn4b    <= w_cn4b;
          r_n       <= r_n + 2'd1;
          if (r_n == 2'd3) begin
            r_state   <= ST_OUT0;
            r_busy    <= 1'b0;
            r_out_vld <= 1'b1;
            r_uo      <= r_f[7:0];
            r_cout    <= ~w_cn4b;
            r_aeb     <= (&w_f) & (&r_eq[2:0]);
          end
        end
        ST_OUT0: begin
          if (w_out_ack) begin
            r_state <= ST_OUT1;
            r_uo    <= r_f[15:8];
          end
        end
        ST_OUT1: begin
          if (w_out_ack) begin
            r_state <= ST_OUT2;
            r_uo    <= {6'b0, r_aeb, r_cout};
          end
        end
        ST_OUT2: begin
          if (w_out_ack) begin
            r_state   <= ST_LOAD;
            r_uo      <= 8'h0;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  assign uo_out  = r_uo;
  assign uio_out = {1'b0, r_busy, r_aeb, r_cout, r_out_vld, r_in_rdy, 2'b00};
  assign uio_oe  = 8'b0111_1100;
endmodule

// File: tb/tb_tt_um_alu16_seq.sv
// Bench for tt_um_alu16_seq: directed literal cases plus randomized ops checked each cycle against a transaction-level model.
module tb_tt_um_alu16_seq;
  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  tt_um_alu16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Datasheet-level reference: arithmetic result per S (A plus B, A minus B minus 1, AB minus 1,
  // A plus (A+~B)), logic result per S; carry-out always from the arithmetic sum.
  function automatic logic [17:0] alu_ref(input logic [15:0] a, input logic [15:0] b, input logic [5:0] cmd);
    logic [16:0] ar;
    logic [15:0] lg;
    logic [16:0] cin;
    logic [15:0] f;
    cin = {16'b0, ~cmd[5]};
    ar  = 17'h0;
    lg  = 16'h0;
    case (cmd[3:0])
      4'b1001: begin ar = {1'b0, a} + {1'b0, b} + cin;          lg = ~(a ^ b); end
      4'b0110: begin ar = {1'b0, a} + {1'b0, ~b} + cin;         lg = a ^ b;    end
      4'b1011: begin ar = {1'b0, a & b} + 17'h0FFFF + cin;      lg = a & b;    end
      4'b1110: begin ar = {1'b0, a} + {1'b0, a | ~b} + cin;     lg = a | b;    end
      default: begin ar = 17'h0; lg = 16'h0; end
    endcase
    f = cmd[4] ? lg : ar[15:0];
    return {ar[16], (f == 16'hFFFF), f};
  endfunction

  // Transaction model: phase 0 = loading, 1 = computing, 2 = offering bytes.
  int          m_phase, m_k, m_left, m_oi;
  logic [15:0] m_a, m_b, m_f;
  logic [5:0]  m_cmd;
  logic        m_cout, m_aeb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_k = 0; m_left = 0; m_oi = 0; m_cout = 0; m_aeb = 0;
    end else begin
      case (m_phase)
        0: if (uio_in[0]) begin
          case (m_k)
            0: m_a[7:0]  = ui_in;
            1: m_a[15:8] = ui_in;
            2: m_b[7:0]  = ui_in;
            3: m_b[15:8] = ui_in;
            default: m_cmd = ui_in[5:0];
          endcase
          if (m_k == 4) begin
            m_k = 0; m_phase = 1; m_left = 4; m_cout = 0; m_aeb = 0;
          end else m_k++;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            {m_cout, m_aeb, m_f} = alu_ref(m_a, m_b, m_cmd);
            m_phase = 2; m_oi = 0;
          end
        end
        default: if (uio_in[1]) begin
          if (m_oi == 2) m_phase = 0;
          else m_oi++;
        end
      endcase
    end
  end

  logic [7:0] exp_uo, exp_uio;
  always_comb begin
    exp_uo = 8'h0;
    if (m_phase == 2)
      exp_uo = (m_oi == 0) ? m_f[7:0] : (m_oi == 1) ? m_f[15:8] : {6'b0, m_aeb, m_cout};
    exp_uio = {1'b0, m_phase == 1, m_aeb, m_cout, m_phase == 2, m_phase == 0, 2'b00};
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_uo_out", uo_out, exp_uo);
      check("cyc_uio_out", uio_out, exp_uio);
      check("cyc_uio_oe", uio_oe, 8'h7C);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    ui_in = b;
    uio_in[0] = 1'b1;
    @(negedge clk);
    uio_in[0] = 1'b0;
    ui_in = 8'($urandom);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [7:0] cmd,
                        input bit gaps, input bit lit, input logic [7:0] e0, input logic [7:0] e1,
                        input logic [7:0] e2, input int hold, input bit busy_vld, input string nm);
    logic [7:0] bytes [5];
    logic [7:0] got [3];
    int cnt;
    bytes = '{a[7:0], a[15:8], b[7:0], b[15:8], cmd};
    for (int i = 0; i < 5; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(bytes[i]);
    end
    if (busy_vld) begin
      uio_in[0] = 1'b1;
      ui_in = 8'($urandom);
    end
    cnt = 0;
    while (uio_out[3] !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, "_latency"}, cnt, 4);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (lit) check({nm, "_hold_b0"}, uo_out, e0);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) uio_in[0] = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      got[i] = uo_out;
      uio_in[1] = 1'b1;
      @(negedge clk);
      uio_in[1] = 1'b0;
    end
    check({nm, "_in_ready"}, uio_out[2], 1);
    if (lit) begin
      check({nm, "_b0"}, got[0], e0);
      check({nm, "_b1"}, got[1], e1);
      check({nm, "_b2"}, got[2], e2);
    end
  endtask

  initial begin
    logic [3:0] s;
    logic [7:0] c;
    rst_n = 1; ena = 1; ui_in = 0; uio_in = 0;
    #1 rst_n = 0;
    #2;
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h04);
    check("rst_uio_oe", uio_oe, 8'h7C);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;

    run_op(16'h1234, 16'h0FCD, 8'h29, 0, 1, 8'h01, 8'h22, 8'h00, 10, 0, "add");
    run_op(16'hFFFF, 16'h0001, 8'h29, 0, 1, 8'h00, 8'h00, 8'h01, 0, 0, "add_wrap");
    run_op(16'h0005, 16'h0007, 8'h06, 1, 1, 8'hFE, 8'hFF, 8'h00, 0, 0, "sub");
    run_op(16'h5A5A, 16'h5A5A, 8'h26, 0, 1, 8'hFF, 8'hFF, 8'h02, 0, 1, "cmp_eq");
    run_op(16'hF0F0, 16'h3C3C, 8'h3B, 1, 1, 8'h30, 8'h30, 8'h01, 0, 1, "and");
    run_op(16'hF0F0, 16'h3C3C, 8'h3E, 0, 1, 8'hFC, 8'hFC, 8'h01, 0, 0, "or");
    run_op(16'hF0F0, 16'h3C3C, 8'h36, 1, 1, 8'hCC, 8'hCC, 8'h01, 0, 0, "xor");

    // Asynchronous reset while computing.
    send_byte(8'h34); send_byte(8'h12); send_byte(8'hCD); send_byte(8'h0F); send_byte(8'h29);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("rst_exec_uo_out", uo_out, 8'h00);
    check("rst_exec_uio_out", uio_out, 8'h04);
    @(negedge clk);
    rst_n = 1;
    run_op(16'h1234, 16'h0FCD, 8'h29, 0, 1, 8'h01, 8'h22, 8'h00, 0, 0, "add_after_rst");

    // Reset after a partial load.
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    #2 rst_n = 0;
    #1;
    check("rst_load_uio_out", uio_out, 8'h04);
    @(negedge clk);
    rst_n = 1;
    run_op(16'hFFFF, 16'h0001, 8'h29, 1, 1, 8'h00, 8'h00, 8'h01, 0, 0, "wrap_after_rst");

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0: s = 4'b1001;
        1: s = 4'b0110;
        2: s = 4'b1011;
        default: s = 4'b1110;
      endcase
      c = {2'($urandom), 1'($urandom), 1'($urandom), s};
      run_op(16'($urandom), 16'($urandom), c, 1, 0, 8'h0, 8'h0, 8'h0,
             (t % 5 == 0) ? 3 : 0, (t % 3 == 0), "rnd");
    end
    run_op(16'h0000, 16'h0000, 8'h36, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, "xor_zero");

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
